// File: rtl/io_input_conditioner.sv
// Input conditioner for the 0xfff0 IO port: synchronises and debounces SW1/SW0/PB0, detects PB0 presses.
// Optional macro PB_PRESS_COUNT_EN adds a saturating 8-bit press counter in io_rdata[15:8].
module io_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CNT_W           = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [2:0]  sw_raw,
  input  logic [15:0] addr,
  input  logic        read,
  output logic        io_sw1,
  output logic        io_sw0,
  output logic        io_pb0,
  output logic        pb_pulse,
  output logic        pb_pressed,
  output logic [15:0] io_rdata
);

  localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [2:0] deb;
  logic [2:0] sync_out;
  logic [2:0] deb_fire;
  logic       pb_rise;
  logic       rd_clear;
  logic [7:0] press_cnt;

  // One independent synchroniser + debouncer per channel.
  for (genvar i = 0; i < 3; i++) begin : g_ch
    logic             s1;
    logic             s2;
    logic             deb_q;
    logic [CNT_W-1:0] cnt;
    logic             fire;

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        s1 <= 1'b0;
        s2 <= 1'b0;
      end else begin
        s1 <= sw_raw[i];
        s2 <= s1;
      end
    end

    assign fire = (s2 != deb_q) && (cnt == TERM_CNT);

    // A bounce back to the debounced level drops the count to zero.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        deb_q <= 1'b0;
        cnt   <= '0;
      end else if (s2 == deb_q) begin
        cnt <= '0;
      end else if (fire) begin
        deb_q <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end

    assign deb[i]      = deb_q;
    assign sync_out[i] = s2;
    assign deb_fire[i] = fire;
  end

  // Debounced PB0 is about to go 0 -> 1 at this edge.
  assign pb_rise  = deb_fire[0] && sync_out[0];
  assign rd_clear = read && (addr == 16'hfff0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pb_pulse <= 1'b0;
    end else begin
      pb_pulse <= pb_rise;
    end
  end

  // A press arriving on the same edge as the clearing read keeps the flag set.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pb_pressed <= 1'b0;
    end else if (pb_rise) begin
      pb_pressed <= 1'b1;
    end else if (rd_clear) begin
      pb_pressed <= 1'b0;
    end
  end

`ifdef PB_PRESS_COUNT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      press_cnt <= 8'h00;
    end else if (rd_clear) begin
      press_cnt <= pb_rise ? 8'h01 : 8'h00;
    end else if (pb_rise && (press_cnt != 8'hff)) begin
      press_cnt <= press_cnt + 8'd1;
    end
  end
`else
  assign press_cnt = 8'h00;
`endif

  assign io_sw1   = deb[2];
  assign io_sw0   = deb[1];
  assign io_pb0   = deb[0];
  assign io_rdata = {press_cnt, 4'd0, pb_pressed, deb[2], deb[1], deb[0]};

endmodule

// File: tb/tb_io_input_conditioner.sv
// Directed bench for io_input_conditioner with DEBOUNCE_CYCLES=4; expected values queued on drive, popped on check.
module tb_io_input_conditioner;

  logic        clock;
  logic        reset_n;
  logic [2:0]  sw_raw;
  logic [15:0] addr;
  logic        read;
  logic        io_sw1;
  logic        io_sw0;
  logic        io_pb0;
  logic        pb_pulse;
  logic        pb_pressed;
  logic [15:0] io_rdata;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

`ifdef PB_PRESS_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  io_input_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(16)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .sw_raw     (sw_raw),
    .addr       (addr),
    .read       (read),
    .io_sw1     (io_sw1),
    .io_sw0     (io_sw0),
    .io_pb0     (io_pb0),
    .pb_pulse   (pb_pulse),
    .pb_pressed (pb_pressed),
    .io_rdata   (io_rdata)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [15:0] e);
    exp_q.push_back(e);
  endtask

  // Scoreboard: pop the oldest expectation and compare.
  task automatic chk(input string tag, input logic [15:0] obs);
    logic [15:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s observed=%h expected=<queue empty>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, e);
      end
    end
  endtask

  function automatic logic [15:0] word(input logic [7:0] cnt, input logic pr,
                                       input logic s1, input logic s0, input logic p0);
    return {(CNT_EN ? cnt : 8'h00), 4'd0, pr, s1, s0, p0};
  endfunction

  initial begin
    reset_n = 1'b0;
    sw_raw  = 3'b111;
    addr    = 16'h0000;
    read    = 1'b0;

    // Reset with inputs high: everything held at zero.
    step(3);
    push(16'h0000); chk("reset_rdata", io_rdata);
    push(16'h0000); chk("reset_pulse", {15'd0, pb_pulse});
    push(16'h0000); chk("reset_pressed", {15'd0, pb_pressed});
    reset_n = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      push(16'h0000); step(1); chk($sformatf("post_reset_edge%0d", i), io_rdata);
    end
    // Edge 6: all three rise; PB0 rising also registers a press.
    push(word(8'd1, 1'b1, 1'b1, 1'b1, 1'b1)); step(1); chk("post_reset_edge6", io_rdata);
    push(16'h0001); chk("post_reset_pulse", {15'd0, pb_pulse});
    read = 1'b1; addr = 16'hfff0;
    push(16'h0007); step(1); chk("post_reset_cleared", io_rdata);
    read = 1'b0;

    // All low; PB0 release gives no pulse.
    sw_raw = 3'b000;
    for (int i = 1; i <= 6; i++) begin
      push(16'h0000); step(1); chk($sformatf("release_pulse%0d", i), {15'd0, pb_pulse});
    end
    push(16'h0000); chk("all_low", io_rdata);

    // SW0 rise.
    sw_raw = 3'b010;
    for (int i = 1; i <= 5; i++) begin
      push(16'h0000); step(1); chk($sformatf("sw0_wait%0d", i), {15'd0, io_sw0});
    end
    push(16'h0002); step(1); chk("sw0_rdata", io_rdata);
    push(16'h0000); chk("sw0_no_pulse", {15'd0, pb_pulse});

    // SW1 bounce: high 3, low 1, then high held.
    sw_raw = 3'b110;
    for (int i = 1; i <= 3; i++) begin
      push(16'h0000); step(1); chk($sformatf("sw1_bounce_hi%0d", i), {15'd0, io_sw1});
    end
    sw_raw = 3'b010;
    push(16'h0000); step(1); chk("sw1_bounce_lo", {15'd0, io_sw1});
    sw_raw = 3'b110;
    for (int i = 1; i <= 5; i++) begin
      push(16'h0000); step(1); chk($sformatf("sw1_settle%0d", i), {15'd0, io_sw1});
    end
    push(16'h0006); step(1); chk("sw1_rdata", io_rdata);

    // PB press with switches low.
    sw_raw = 3'b000;
    step(6);
    push(16'h0000); chk("pb_pre_low", io_rdata);
    sw_raw = 3'b001;
    step(5);
    push(16'h0000); chk("pb_pre_pulse", {15'd0, pb_pulse});
    push(16'h0001); step(1); chk("pb_pulse_hi", {15'd0, pb_pulse});
    push(word(8'd1, 1'b1, 1'b0, 1'b0, 1'b1)); chk("pb_rdata", io_rdata);
    push(16'h0000); step(1); chk("pb_pulse_one_cycle", {15'd0, pb_pulse});
    read = 1'b1; addr = 16'hfffa;
    push(16'h0001); step(1); chk("pb_read_other_addr", {15'd0, pb_pressed});
    read = 1'b0; addr = 16'hfff0;
    push(16'h0001); step(1); chk("pb_no_read_en", {15'd0, pb_pressed});
    read = 1'b1;
    push(16'h0001); step(1); chk("pb_read_clear", io_rdata);
    read = 1'b0;

    // Set/clear collision: clearing read on the press edge.
    sw_raw = 3'b000;
    step(6);
    push(16'h0000); chk("coll_low", io_rdata);
    sw_raw = 3'b001;
    step(5);
    read = 1'b1; addr = 16'hfff0;
    push(word(8'd1, 1'b1, 1'b0, 1'b0, 1'b1)); step(1); chk("coll_set_wins", io_rdata);
    read = 1'b0;

    // Mid-count reset on SW0.
    sw_raw = 3'b011;
    step(4);
    reset_n = 1'b0;
    #1;
    push(16'h0000); chk("midreset_immediate", io_rdata);
    step(2);
    reset_n = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      push(16'h0000); step(1); chk($sformatf("midreset_wait%0d", i), io_rdata);
    end
    push(word(8'd1, 1'b1, 1'b0, 1'b1, 1'b1)); step(1); chk("midreset_edge6", io_rdata);

    // 300 further presses without a read; counter saturates.
    if (CNT_EN) begin
      for (int p = 0; p < 300; p++) begin
        sw_raw = 3'b010; step(6);
        sw_raw = 3'b011; step(6);
      end
      push(16'h00ff); chk("press_cnt_sat", {8'h00, io_rdata[15:8]});
      read = 1'b1; addr = 16'hfff0;
      push(16'h0003); step(1); chk("press_cnt_cleared", io_rdata);
      read = 1'b0;
    end

    // Final report
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
